// File: rtl/jtgng_obj_dma.sv
// Object RAM DMA: copies LEN entries from CPU object RAM to the sprite line RAM while
// holding the CPU bus. Optional macro JTGNG_OBJ_DMA_CLEAR_EN adds a clr input (fill with 1s).
module jtgng_obj_dma #(
    parameter int unsigned dw  = 8,
    parameter int unsigned aw  = 9,
    parameter int unsigned LEN = 384
) (
    input  logic          rst_n,
    input  logic          clk,
    input  logic          cen,
    input  logic          start,
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
    input  logic          clr,
`endif
    output logic          busrq,
    input  logic          busak,
    output logic [aw-1:0] src_addr,
    input  logic [dw-1:0] src_data,
    output logic [aw-1:0] dst_addr,
    output logic [dw-1:0] dst_data,
    output logic          dst_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRd,
        StWr,
        StFin
    } state_e;

    localparam logic [aw-1:0] LastIdx = aw'(LEN - 1);

    state_e        state_q;
    logic [aw-1:0] count_q;
    logic          busrq_q;
    logic          busy_q;
    logic          done_q;
    logic          wr_q;
    logic          kick;

`ifdef JTGNG_OBJ_DMA_CLEAR_EN
    logic fill_q;

    assign kick = start | clr;
`else
    assign kick = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            busrq_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
            fill_q  <= 1'b0;
`endif
        end else if (cen) begin
            unique case (state_q)
                StIdle: begin
                    if (kick) begin
                        state_q <= StReq;
                        count_q <= '0;
                        busrq_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
                        fill_q  <= clr;
`endif
                    end
                end
                StReq: begin
                    if (busak) begin
                        state_q <= StRd;
                    end
                end
                // Losing the grant in RD or WR freezes everything until it returns.
                StRd: begin
                    if (busak) begin
                        state_q <= StWr;
                        wr_q    <= 1'b1;
                    end
                end
                StWr: begin
                    if (busak) begin
                        wr_q <= 1'b0;
                        if (count_q == LastIdx) begin
                            state_q <= StFin;
                            busrq_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRd;
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busrq_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busrq    = busrq_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign src_addr = count_q;
    assign dst_addr = count_q;
    assign dst_we   = wr_q & busak;

    // Source data arrives one cen cycle after src_addr, i.e. during WR.
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
    assign dst_data = !wr_q ? '0 : (fill_q ? {dw{1'b1}} : src_data);
`else
    assign dst_data = wr_q ? src_data : '0;
`endif

endmodule

// File: tb/tb_jtgng_obj_dma.sv
// Directed bench for jtgng_obj_dma with LEN=4: copy, grant delay, stall, restart,
// mid-transfer reset, half-rate cen and (with JTGNG_OBJ_DMA_CLEAR_EN) clear fill.
module tb_jtgng_obj_dma;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic       start = 1'b0;
    logic       busak = 1'b0;
    logic       busrq;
    logic [8:0] src_addr;
    logic [7:0] src_data = 8'h00;
    logic [8:0] dst_addr;
    logic [7:0] dst_data;
    logic       dst_we;
    logic       busy;
    logic       done;
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
    logic       clr = 1'b0;
`endif

    logic [7:0] src_mem [4];
    logic [8:0] wa [8];
    logic [7:0] wd [8];
    int nw = 0;
    int ndone = 0;
    int ccount = 0;
    int g_at = 0;
    int done_at = 0;
    logic done_rq = 1'b0;
    bit armed = 1'b0;
    bit half = 1'b0;
    int pass_n = 0;
    int total = 0;

    jtgng_obj_dma #(
        .dw (8),
        .aw (9),
        .LEN(4)
    ) u_dut (
        .rst_n   (rst_n),
        .clk     (clk),
        .cen     (cen),
        .start   (start),
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
        .clr     (clr),
`endif
        .busrq   (busrq),
        .busak   (busak),
        .src_addr(src_addr),
        .src_data(src_data),
        .dst_addr(dst_addr),
        .dst_data(dst_data),
        .dst_we  (dst_we),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Synchronous object RAM: data valid one cen cycle after the address.
    always @(posedge clk) begin
        if (cen) src_data <= (src_addr < 9'd4) ? src_mem[src_addr[1:0]] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_n++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Log the current cycle's outputs, then advance one clock.
    task automatic step();
        #2;
        if (cen) begin
            if (armed && busrq && busak) begin
                g_at  = ccount;
                armed = 1'b0;
            end
            if (dst_we) begin
                if (nw < 8) begin
                    wa[nw] = dst_addr;
                    wd[nw] = dst_data;
                end
                nw++;
            end
            if (done) begin
                ndone++;
                done_at = ccount;
                done_rq = busrq;
            end
            ccount++;
        end
        @(posedge clk);
        #1;
        if (half) cen = ~cen;
    endtask

    // Request a transfer, hold off the grant for pre_wait cycles, then grant.
    task automatic go(input string tag, input bit use_clr, input int pre_wait);
        nw    = 0;
        armed = 1'b1;
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
        if (use_clr) clr = 1'b1;
`endif
        start = 1'b1;
        for (int i = 0; i < 10 && !busrq; i++) step();
        start = 1'b0;
`ifdef JTGNG_OBJ_DMA_CLEAR_EN
        clr = 1'b0;
`endif
        check({tag, "_busrq_up"}, busrq, 1'b1);
        for (int i = 0; i < pre_wait; i++) begin
            #1;
            check($sformatf("%s_wait%0d_busrq", tag, i), busrq, 1'b1);
            check($sformatf("%s_wait%0d_we", tag, i), dst_we, 1'b0);
            step();
        end
        busak = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n0;
        n0 = ndone;
        for (int i = 0; i < 80 && ndone == n0; i++) step();
        check({tag, "_done_seen"}, ndone - n0, 1);
        busak = 1'b0;
    endtask

    task automatic check_writes(input string tag, input bit fill);
        check({tag, "_nwrites"}, nw, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), wa[i], i);
            check($sformatf("%s_wr%0d_data", tag, i), wd[i], fill ? 8'hFF : src_mem[i]);
        end
    endtask

    initial begin
        src_mem[0] = 8'h11;
        src_mem[1] = 8'h22;
        src_mem[2] = 8'h33;
        src_mem[3] = 8'h44;

        // Reset values
        #3;
        check("rst_busrq", busrq, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", dst_we, 1'b0);
        check("rst_src_addr", src_addr, 9'd0);
        check("rst_dst_addr", dst_addr, 9'd0);
        check("rst_dst_data", dst_data, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic copy, grant on the cycle after busrq
        go("s1", 1'b0, 1);
        wait_done("s1");
        check("s1_latency", done_at - g_at, 9);
        check("s1_busrq_fin", done_rq, 1'b0);
        check_writes("s1", 1'b0);
        check("s1_busy_idle", busy, 1'b0);
        check("s1_count_nowrap", src_addr, 9'd3);
        step();

        // Grant withheld for 5 cycles
        go("s2", 1'b0, 5);
        wait_done("s2");
        check("s2_latency", done_at - g_at, 9);
        check_writes("s2", 1'b0);
        step();

        // Grant dropped for 3 cen cycles in WR of entry 2
        go("s3", 1'b0, 1);
        for (int i = 0; i < 6; i++) step();
        busak = 1'b0;
        #1;
        check("s3_stall_we", dst_we, 1'b0);
        check("s3_pre_nw", nw, 2);
        for (int i = 0; i < 3; i++) step();
        check("s3_stall_nw", nw, 2);
        busak = 1'b1;
        wait_done("s3");
        check("s3_latency", done_at - g_at, 12);
        check_writes("s3", 1'b0);
        step();

        // start pulsed again during entry 1
        begin
            int n0;
            n0 = ndone;
            go("s4", 1'b0, 1);
            for (int i = 0; i < 3; i++) step();
            start = 1'b1;
            step();
            start = 1'b0;
            wait_done("s4");
            for (int i = 0; i < 10; i++) step();
            check("s4_one_done", ndone - n0, 1);
            check("s4_busrq_idle", busrq, 1'b0);
            check("s4_busy_idle", busy, 1'b0);
            check_writes("s4", 1'b0);
        end

        // Reset asserted in WR of entry 2
        begin
            int n0;
            go("s5", 1'b0, 1);
            for (int i = 0; i < 6; i++) step();
            #1;
            check("s5_pre_we", dst_we, 1'b1);
            check("s5_pre_data", dst_data, 8'h33);
            n0 = ndone;
            rst_n = 1'b0;
            busak = 1'b0;
            #1;
            check("s5_rst_busrq", busrq, 1'b0);
            check("s5_rst_busy", busy, 1'b0);
            check("s5_rst_done", done, 1'b0);
            check("s5_rst_we", dst_we, 1'b0);
            check("s5_rst_src_addr", src_addr, 9'd0);
            check("s5_rst_dst_addr", dst_addr, 9'd0);
            check("s5_rst_dst_data", dst_data, 8'd0);
            step();
            step();
            check("s5_rst_nw", nw, 2);
            check("s5_rst_nodone", ndone - n0, 0);
            rst_n = 1'b1;
            step();
            go("s5b", 1'b0, 1);
            wait_done("s5b");
            check("s5b_latency", done_at - g_at, 9);
            check_writes("s5b", 1'b0);
            step();
        end

        // cen toggling every cycle
        half = 1'b1;
        go("s6", 1'b0, 1);
        wait_done("s6");
        check("s6_latency", done_at - g_at, 9);
        check_writes("s6", 1'b0);
        check("s6_busy_idle", busy, 1'b0);
        half = 1'b0;
        cen = 1'b1;
        step();

`ifdef JTGNG_OBJ_DMA_CLEAR_EN
        // Clear fill, with start also high to check clr priority
        go("s7", 1'b1, 1);
        wait_done("s7");
        check("s7_latency", done_at - g_at, 9);
        check_writes("s7", 1'b1);
        step();
`endif

        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end

endmodule
